product_accumulator: RTL and testbench

Sequential accumulation stage directly downstream of the 4-bit array multiplier. It consumes the multiplier's 8-bit product stream under a valid/ready handshake and sums a fixed number of products into one dot-product result. It presents that result on a second valid/ready handshake and holds it until taken. One clock domain; all datapath state is registered.

---
 rtl/product_accumulator.sv | 91 +++++++++
 tb/tb_product_accumulator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums N_TERMS multiplier products into one dot-product result.
// The result is held on a valid/ready handshake until the consumer takes it.
module product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [7:0]       prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             ovf,
    output logic [7:0]       term_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int          SUM_W = ACC_W + 1;
    localparam logic [7:0]  LAST  = 8'(N_TERMS);

    state_t           state;
    logic [ACC_W:0]   sum;
    logic [7:0]       cnt_next;

    // The extra top bit of sum is the carry that feeds the sticky overflow flag.
    assign sum        = {1'b0, acc_out} + SUM_W'(prod_in);
    assign cnt_next   = term_cnt + 8'd1;
    assign prod_ready = (state != HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            ovf       <= 1'b0;
            term_cnt  <= 8'd0;
        end else if (clear) begin
            state     <= IDLE;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            ovf       <= 1'b0;
            term_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (prod_valid) begin
                        acc_out  <= ACC_W'(prod_in);
                        term_cnt <= 8'd1;
                        ovf      <= 1'b0;
                        if (N_TERMS == 1) begin
                            state     <= HOLD;
                            acc_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc_out  <= sum[ACC_W-1:0];
                        ovf      <= ovf | sum[ACC_W];
                        term_cnt <= cnt_next;
                        if (cnt_next == LAST) begin
                            state     <= HOLD;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        state     <= IDLE;
                        acc_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default instance plus a narrow
// ACC_W=9 instance sharing the same stimulus to exercise overflow.
module tb_product_accumulator;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [7:0]  prod_in;
    logic        prod_valid;
    logic        acc_ready;

    logic        prod_ready;
    logic [11:0] acc_out;
    logic        acc_valid;
    logic        ovf;
    logic [7:0]  term_cnt;

    logic        prod_ready9;
    logic [8:0]  acc_out9;
    logic        acc_valid9;
    logic        ovf9;
    logic [7:0]  term_cnt9;

    int total;
    int bad;

    product_accumulator dut (
        .clk(clk), .rst(rst), .clear(clear),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .ovf(ovf), .term_cnt(term_cnt)
    );

    product_accumulator #(.N_TERMS(4), .ACC_W(9)) dut9 (
        .clk(clk), .rst(rst), .clear(clear),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready9),
        .acc_out(acc_out9), .acc_valid(acc_valid9), .acc_ready(acc_ready),
        .ovf(ovf9), .term_cnt(term_cnt9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++; if (acc_out !== 12'd0) begin bad++; $display("[TB] FAIL reset_acc got=%0d exp=0", acc_out); end
        total++; if (acc_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b exp=0", acc_valid); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf got=%0b exp=0", ovf); end
        total++; if (term_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d exp=0", term_cnt); end
        total++; if (prod_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%0b exp=1", prod_ready); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] prods [4];
        prods = '{8'd15, 8'd14, 8'd225, 8'd1};
        acc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            prod_valid = 1'b1;
            prod_in    = prods[i];
            step();
            if (i < 3) begin
                total++; if (acc_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_valid i=%0d got=%0b exp=0", i, acc_valid); end
                total++; if (term_cnt !== 8'(i + 1)) begin bad++; $display("[TB] FAIL basic_cnt i=%0d got=%0d exp=%0d", i, term_cnt, i + 1); end
            end
        end
        prod_valid = 1'b0;
        total++; if (acc_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid got=%0b exp=1", acc_valid); end
        total++; if (acc_out !== 12'd255) begin bad++; $display("[TB] FAIL basic_acc got=%0d exp=255", acc_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL basic_ovf got=%0b exp=0", ovf); end
        total++; if (term_cnt !== 8'd4) begin bad++; $display("[TB] FAIL basic_cnt4 got=%0d exp=4", term_cnt); end
        total++; if (prod_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_hold_ready got=%0b exp=0", prod_ready); end
        step();
        total++; if (acc_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_valid_fall got=%0b exp=0", acc_valid); end
        total++; if (acc_out !== 12'd255) begin bad++; $display("[TB] FAIL basic_retain got=%0d exp=255", acc_out); end
    endtask

    task automatic test_gaps();
        int gaps [4];
        int expect_acc;
        gaps = '{0, 2, 1, 3};
        expect_acc = 255;
        acc_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                prod_valid = 1'b0;
                prod_in    = 8'hAA;
                step();
                total++; if (prod_ready !== 1'b1) begin bad++; $display("[TB] FAIL gap_ready k=%0d got=%0b exp=1", k, prod_ready); end
                total++; if (acc_out !== 12'(expect_acc)) begin bad++; $display("[TB] FAIL gap_acc k=%0d got=%0d exp=%0d", k, acc_out, expect_acc); end
            end
            prod_valid = 1'b1;
            prod_in    = 8'd225;
            step();
            expect_acc = (k == 0) ? 225 : expect_acc + 225;
            total++; if (acc_out !== 12'(expect_acc)) begin bad++; $display("[TB] FAIL gap_sum k=%0d got=%0d exp=%0d", k, acc_out, expect_acc); end
        end
        prod_valid = 1'b0;
        total++; if (acc_valid !== 1'b1) begin bad++; $display("[TB] FAIL gap_valid got=%0b exp=1", acc_valid); end
        total++; if (acc_out !== 12'd900) begin bad++; $display("[TB] FAIL gap_acc900 got=%0d exp=900", acc_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL gap_ovf got=%0b exp=0", ovf); end
        total++; if (acc_out9 !== 9'd388) begin bad++; $display("[TB] FAIL narrow_acc got=%0d exp=388", acc_out9); end
        total++; if (ovf9 !== 1'b1) begin bad++; $display("[TB] FAIL narrow_ovf got=%0b exp=1", ovf9); end
        step();
    endtask

    task automatic test_backpressure();
        acc_ready = 1'b0;
        for (int p = 1; p <= 4; p++) begin
            prod_valid = 1'b1;
            prod_in    = 8'(p);
            step();
        end
        prod_in = 8'd50;
        for (int c = 0; c < 10; c++) begin
            total++; if (acc_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid c=%0d got=%0b exp=1", c, acc_valid); end
            total++; if (prod_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready c=%0d got=%0b exp=0", c, prod_ready); end
            total++; if (acc_out !== 12'd10) begin bad++; $display("[TB] FAIL bp_acc c=%0d got=%0d exp=10", c, acc_out); end
            total++; if (term_cnt !== 8'd4) begin bad++; $display("[TB] FAIL bp_cnt c=%0d got=%0d exp=4", c, term_cnt); end
            step();
        end
        acc_ready = 1'b1;
        step();
        total++; if (acc_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release got=%0b exp=0", acc_valid); end
        total++; if (prod_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_back got=%0b exp=1", prod_ready); end
        total++; if (acc_out !== 12'd10) begin bad++; $display("[TB] FAIL bp_retain got=%0d exp=10", acc_out); end
        step();
        total++; if (acc_out !== 12'd50) begin bad++; $display("[TB] FAIL bp_first got=%0d exp=50", acc_out); end
        total++; if (term_cnt !== 8'd1) begin bad++; $display("[TB] FAIL bp_first_cnt got=%0d exp=1", term_cnt); end
        prod_in = 8'd0;
        for (int c = 0; c < 3; c++) step();
        prod_valid = 1'b0;
        total++; if (acc_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_group2_valid got=%0b exp=1", acc_valid); end
        total++; if (acc_out !== 12'd50) begin bad++; $display("[TB] FAIL bp_group2_acc got=%0d exp=50", acc_out); end
        step();
    endtask

    task automatic test_clear();
        acc_ready  = 1'b1;
        prod_valid = 1'b1;
        prod_in    = 8'd10;
        step();
        prod_in = 8'd20;
        step();
        total++; if (acc_out !== 12'd30) begin bad++; $display("[TB] FAIL clr_partial got=%0d exp=30", acc_out); end
        clear   = 1'b1;
        prod_in = 8'd30;
        step();
        clear = 1'b0;
        total++; if (term_cnt !== 8'd0) begin bad++; $display("[TB] FAIL clr_cnt got=%0d exp=0", term_cnt); end
        total++; if (acc_out !== 12'd0) begin bad++; $display("[TB] FAIL clr_acc got=%0d exp=0", acc_out); end
        total++; if (acc_valid !== 1'b0) begin bad++; $display("[TB] FAIL clr_valid got=%0b exp=0", acc_valid); end
        for (int p = 1; p <= 4; p++) begin
            prod_in = 8'(p);
            step();
        end
        prod_valid = 1'b0;
        total++; if (acc_valid !== 1'b1) begin bad++; $display("[TB] FAIL clr_after_valid got=%0b exp=1", acc_valid); end
        total++; if (acc_out !== 12'd10) begin bad++; $display("[TB] FAIL clr_after_acc got=%0d exp=10", acc_out); end
        step();
    endtask

    task automatic test_rst_async();
        acc_ready  = 1'b0;
        prod_valid = 1'b1;
        prod_in    = 8'd7;
        for (int c = 0; c < 4; c++) step();
        prod_valid = 1'b0;
        total++; if (acc_out !== 12'd28) begin bad++; $display("[TB] FAIL rst_pre_acc got=%0d exp=28", acc_out); end
        total++; if (acc_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_valid got=%0b exp=1", acc_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (acc_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_valid got=%0b exp=0", acc_valid); end
        total++; if (acc_out !== 12'd0) begin bad++; $display("[TB] FAIL rst_async_acc got=%0d exp=0", acc_out); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_ovf got=%0b exp=0", ovf); end
        total++; if (term_cnt !== 8'd0) begin bad++; $display("[TB] FAIL rst_async_cnt got=%0d exp=0", term_cnt); end
        total++; if (prod_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_async_ready got=%0b exp=1", prod_ready); end
        @(negedge clk);
        rst        = 1'b0;
        acc_ready  = 1'b1;
        prod_valid = 1'b1;
        prod_in    = 8'd1;
        for (int c = 0; c < 4; c++) step();
        prod_valid = 1'b0;
        total++; if (acc_out !== 12'd4) begin bad++; $display("[TB] FAIL rst_after_acc got=%0d exp=4", acc_out); end
        total++; if (acc_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst_after_valid got=%0b exp=1", acc_valid); end
        step();
    endtask

    task automatic test_back_to_back();
        int valid_cycles;
        valid_cycles = 0;
        acc_ready  = 1'b1;
        prod_valid = 1'b1;
        prod_in    = 8'd2;
        for (int c = 0; c < 10; c++) begin
            step();
            if (acc_valid === 1'b1) valid_cycles++;
        end
        prod_valid = 1'b0;
        total++; if (valid_cycles != 2) begin bad++; $display("[TB] FAIL b2b_results got=%0d exp=2", valid_cycles); end
        total++; if (acc_out !== 12'd8) begin bad++; $display("[TB] FAIL b2b_acc got=%0d exp=8", acc_out); end
        total++; if (acc_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle got=%0b exp=0", acc_valid); end
        step();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b0;
        clear      = 1'b0;
        prod_in    = 8'd0;
        prod_valid = 1'b0;
        acc_ready  = 1'b0;
        #1 rst = 1'b1;
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_clear();
        test_rst_async();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
